fetch_queue: RTL and testbench
==============================

# fetch_queue

Parametrised instruction-fetch stage that owns the PC, issues in-order requests to instruction memory and buffers returned instructions with their PCs in a DEPTH-entry queue. Decode pulls from the queue through a valid/ready handshake. Branch and exception redirects flush the queue and discard any in-flight memory response. It sits between the PC/branch logic and the ID stage, replacing the fixed single-register fetch.

## Interface
- WIDTH, 32, address and instruction width
- DEPTH, 4, queue entries (power of two, ≥2)
- RESET_PC, 32'h0000_0000, PC after reset
- EXC_VECTOR, 32'h8000_0180, exception redirect target

One clock; reset is synchronous and active-high.
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- br  in  1  branch redirect request
- br_target  in  WIDTH  branch target, sampled when br=1
- except  in  1  exception redirect, priority over br
- imem_req  out  1  request valid this cycle
- imem_addr  out  WIDTH  request address (= pc)
- imem_valid  in  1  response valid, one per request, in order, ≥1 cycle after request
- imem_data  in  WIDTH  instruction word
- out_valid  out  1  queue head valid
- out_ready  in  1  decode accepts head
- pc_out  out  WIDTH  PC of head instruction
- inst_out  out  WIDTH  head instruction
- count  out  $clog2(DEPTH)+1  occupancy

## Operation
- States: IDLE (nothing outstanding), WAIT (one request outstanding), DISCARD (one outstanding, response to be dropped).
- imem_req = !reset && !br && !except && ((IDLE && count<DEPTH) || (WAIT && imem_valid && count+1<DEPTH)). imem_addr = pc.
- On issue: req_pc <= pc; pc <= pc+4 (mod 2^WIDTH, wraps); state <= WAIT.
- WAIT, imem_valid: enqueue {req_pc, imem_data}; state <= WAIT if re-issued same cycle else IDLE.
- Pop when out_valid && out_ready. Enqueue and pop in same cycle: count unchanged.
- Redirect (except, else br): pc <= EXC_VECTOR / br_target; queue flushed (count=0, out_valid=0 next cycle); pop ignored; state IDLE→IDLE, WAIT→DISCARD (WAIT with imem_valid same cycle → IDLE, data dropped), DISCARD→DISCARD (with imem_valid → IDLE).
- DISCARD: no requests; imem_valid drops data, state <= IDLE.
- Queue never overflows: credit rule guarantees a slot for every outstanding response.
- Reset: pc=RESET_PC, state IDLE, count 0, out_valid 0, pc_out 0, inst_out 0, imem_req 0; mid-operation reset abandons outstanding request (its late response ignored only if it arrives during reset; memory must be reset alongside).

## Timing
- Memory latency k≥1. Request cycle t, imem_valid t+k, out_valid t+k+1 (bypass off).
- k=1, queue not near full: one request and one enqueue per cycle (full throughput).
- First request: first cycle after reset deasserts, addr RESET_PC.
- Redirect at cycle t (IDLE): first request to target at t+1.
- pc_out/inst_out registered from queue head; hold value while out_valid && !out_ready.

## Configuration
- FETCH_BYPASS_EN defined: when count==0 and imem_valid in WAIT, out_valid/pc_out/inst_out driven combinationally from req_pc/imem_data; entry enqueued only if !out_ready. Latency request→out_valid = k. Redirect same cycle suppresses bypass out_valid.
- Undefined: all outputs from queue registers; latency k+1; no memory→decode combinational path.

## Test plan
- Reset release, k=1, out_ready=1 -> requests 0x0,0x4,0x8 on consecutive cycles; out_valid from cycle 2 with pc_out 0x0,0x4,0x8.
- out_ready=0, k=1, DEPTH=4 -> count saturates at 4, imem_req 0 at count≥3 in WAIT; no data lost after release, order preserved.
- br=1 target 0x100 while request outstanding (k=3) -> stale response dropped, count 0, next request 0x100, pc_out 0x100.
- br and except same cycle -> next request addr 0x8000_0180.
- PC 0xFFFF_FFFC issued -> next request 0x0000_0000.
- FETCH_BYPASS_EN, empty queue, k=1 -> out_valid in cycle after request with pc_out=req address; disabled -> one cycle later.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the PC, keeps at most one memory request in flight and buffers
// returned instructions. Define FETCH_BYPASS_EN to forward a response straight to decode.
module fetch_queue #(
    parameter int unsigned      WIDTH      = 32,
    parameter int unsigned      DEPTH      = 4,
    parameter logic [WIDTH-1:0] RESET_PC   = 32'h0000_0000,
    parameter logic [WIDTH-1:0] EXC_VECTOR = 32'h8000_0180
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   br,
    input  logic [WIDTH-1:0]       br_target,
    input  logic                   except,
    output logic                   imem_req,
    output logic [WIDTH-1:0]       imem_addr,
    input  logic                   imem_valid,
    input  logic [WIDTH-1:0]       imem_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       pc_out,
    output logic [WIDTH-1:0]       inst_out,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDiscard
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] req_pc_q, req_pc_d;
    logic [WIDTH-1:0] qpc_q   [DEPTH];
    logic [WIDTH-1:0] qpc_d   [DEPTH];
    logic [WIDTH-1:0] qinst_q [DEPTH];
    logic [WIDTH-1:0] qinst_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic             redirect;
    logic [WIDTH-1:0] redirect_pc;
    logic             resp;
    logic             issue;
    logic             enq;
    logic             pop;
    logic             q_nonempty;

    always_comb begin
        redirect    = except || br;
        redirect_pc = except ? EXC_VECTOR : br_target;
        resp        = (state_q == StWait) && imem_valid;
        q_nonempty  = (count_q != '0);
    end

    // Credit rule: only issue when a queue slot is guaranteed for the response.
    always_comb begin
        issue = 1'b0;
        if (!reset && !redirect) begin
            if (state_q == StIdle) begin
                issue = (count_q < CW'(DEPTH));
            end else if (state_q == StWait) begin
                issue = imem_valid && ((count_q + CW'(1)) < CW'(DEPTH));
            end
        end
        imem_req  = issue;
        imem_addr = pc_q;
    end

`ifdef FETCH_BYPASS_EN
    logic bypass;

    always_comb begin
        bypass    = !reset && !redirect && resp && !q_nonempty;
        out_valid = q_nonempty || bypass;
        pc_out    = bypass ? req_pc_q : qpc_q[rd_ptr_q];
        inst_out  = bypass ? imem_data : qinst_q[rd_ptr_q];
        enq       = resp && !redirect && !(bypass && out_ready);
        pop       = q_nonempty && out_ready && !redirect;
    end
`else
    always_comb begin
        out_valid = q_nonempty;
        pc_out    = qpc_q[rd_ptr_q];
        inst_out  = qinst_q[rd_ptr_q];
        enq       = resp && !redirect;
        pop       = q_nonempty && out_ready && !redirect;
    end
`endif

    assign count = count_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (issue) state_d = StWait;
            end
            StWait: begin
                if (imem_valid) begin
                    state_d = issue ? StWait : StIdle;
                end else if (redirect) begin
                    state_d = StDiscard;
                end
            end
            StDiscard: begin
                if (imem_valid) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        if (redirect) begin
            pc_d = redirect_pc;
        end else if (issue) begin
            pc_d     = pc_q + WIDTH'(4);
            req_pc_d = pc_q;
        end
    end

    always_comb begin
        qpc_d    = qpc_q;
        qinst_d  = qinst_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) begin
                qpc_d[wr_ptr_q]   = req_pc_q;
                qinst_d[wr_ptr_q] = imem_data;
                wr_ptr_d          = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({enq, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                qpc_q[i]   <= '0;
                qinst_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            qpc_q    <= qpc_d;
            qinst_q  <= qinst_d;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a single-outstanding instruction memory of programmable
// latency; expected addresses, PCs and counts are hand-derived per cycle.
module tb_fetch_queue;
`ifdef FETCH_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        br = 1'b0;
    logic        except = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_data = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] pc_out;
    logic [31:0] inst_out;
    logic [2:0]  count;

    int n_total = 0;
    int n_bad = 0;

    // memory model state
    int          lat = 1;
    int          cyc = 0;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          pend_due = 0;

    // per-cycle observations
    logic        o_req, o_valid;
    logic [31:0] o_addr, o_pc, o_inst;
    logic [2:0]  o_count;

    fetch_queue #(
        .WIDTH      (32),
        .DEPTH      (4),
        .RESET_PC   (32'h0000_0000),
        .EXC_VECTOR (32'h8000_0180)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .br         (br),
        .br_target  (br_target),
        .except     (except),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_data  (imem_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .pc_out     (pc_out),
        .inst_out   (inst_out),
        .count      (count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle, entered at a falling edge with the other inputs already set.
    task automatic tick();
        if (pend && pend_due == cyc) begin
            imem_valid = 1'b1;
            imem_data  = mem_word(pend_addr);
            pend       = 1'b0;
        end else begin
            imem_valid = 1'b0;
            imem_data  = 32'h0;
        end
        #1;
        o_req   = imem_req;
        o_addr  = imem_addr;
        o_valid = out_valid;
        o_pc    = pc_out;
        o_inst  = inst_out;
        o_count = count;
        if (imem_req) begin
            pend      = 1'b1;
            pend_addr = imem_addr;
            pend_due  = cyc + lat;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset(input int l);
        reset     = 1'b1;
        br        = 1'b0;
        except    = 1'b0;
        br_target = 32'h0;
        out_ready = 1'b1;
        lat       = l;
        pend      = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        cyc   = 0;
    endtask

    initial begin
        @(negedge clk);

        // Reset state, then streaming with k=1 and decode always ready.
        do_reset(1);
        check_val("rst_req", 32'(o_req), 32'd0);
        check_val("rst_valid", 32'(o_valid), 32'd0);
        check_val("rst_count", 32'(o_count), 32'd0);
        check_val("rst_pc_out", o_pc, 32'h0);
        check_val("rst_inst_out", o_inst, 32'h0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check_val("s1_req", 32'(o_req), 32'd1);
            check_val("s1_addr", o_addr, 32'(4 * i));
            if (i >= 2 - BYP) begin
                check_val("s1_valid", 32'(o_valid), 32'd1);
                check_val("s1_pc", o_pc, 32'(4 * (i - 2 + BYP)));
                check_val("s1_inst", o_inst, mem_word(32'(4 * (i - 2 + BYP))));
            end else begin
                check_val("s1_valid_lo", 32'(o_valid), 32'd0);
            end
            if (i == 4) check_val("s1_count", 32'(o_count), 32'(1 - BYP));
        end

        // Backpressure: fill to DEPTH, hold head, drain in order, then flush a non-empty queue.
        do_reset(1);
        out_ready = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (i == 6) out_ready = 1'b1;
            if (i == 12) begin
                out_ready = 1'b0;
                br        = 1'b1;
                br_target = 32'h400;
            end
            if (i == 13) br = 1'b0;
            tick();
            if (i < 4) begin
                check_val("s2_req", 32'(o_req), 32'd1);
                check_val("s2_addr", o_addr, 32'(4 * i));
            end
            if (i >= 4 && i <= 6) check_val("s2_req_stall", 32'(o_req), 32'd0);
            if (i == 4) check_val("s2_count3", 32'(o_count), 32'd3);
            if (i == 5) check_val("s2_count4", 32'(o_count), 32'd4);
            if (i >= 2 && i <= 5) begin
                check_val("s2_hold_valid", 32'(o_valid), 32'd1);
                check_val("s2_hold_pc", o_pc, 32'h0);
            end
            if (i == 7) begin
                check_val("s2_resume_req", 32'(o_req), 32'd1);
                check_val("s2_resume_addr", o_addr, 32'h10);
            end
            if (i >= 6 && i <= 11) begin
                check_val("s2_drain_pc", o_pc, 32'(4 * (i - 6)));
                check_val("s2_drain_inst", o_inst, mem_word(32'(4 * (i - 6))));
            end
            if (i == 12) check_val("s2_br_req", 32'(o_req), 32'd0);
            if (i == 13) begin
                check_val("s2_flush_count", 32'(o_count), 32'd0);
                check_val("s2_flush_valid", 32'(o_valid), 32'd0);
                check_val("s2_br_addr", o_addr, 32'h400);
            end
        end

        // Branch with a k=3 request outstanding: stale response must be dropped.
        do_reset(3);
        for (int i = 0; i < 9; i++) begin
            if (i == 1) begin
                br        = 1'b1;
                br_target = 32'h100;
            end
            if (i == 2) br = 1'b0;
            tick();
            if (i == 0) check_val("s3_addr0", o_addr, 32'h0);
            if (i >= 1 && i <= 3) check_val("s3_req_lo", 32'(o_req), 32'd0);
            if (i == 4) begin
                check_val("s3_req", 32'(o_req), 32'd1);
                check_val("s3_addr", o_addr, 32'h100);
                check_val("s3_count", 32'(o_count), 32'd0);
                check_val("s3_valid_lo", 32'(o_valid), 32'd0);
            end
            if (i == 8 - BYP) begin
                check_val("s3_valid", 32'(o_valid), 32'd1);
                check_val("s3_pc", o_pc, 32'h100);
                check_val("s3_inst", o_inst, mem_word(32'h100));
            end
        end

        // br and except together, then a branch colliding with a response.
        do_reset(1);
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin
                br        = 1'b1;
                except    = 1'b1;
                br_target = 32'h200;
            end
            if (i == 1) begin
                br     = 1'b0;
                except = 1'b0;
            end
            if (i == 2) begin
                br        = 1'b1;
                br_target = 32'h300;
            end
            if (i == 3) br = 1'b0;
            tick();
            if (i == 0) check_val("s4_req_lo", 32'(o_req), 32'd0);
            if (i == 1) check_val("s4_exc_addr", o_addr, 32'h8000_0180);
            if (i == 2) check_val("s4_br_valid_lo", 32'(o_valid), 32'd0);
            if (i == 3) begin
                check_val("s4_br_addr", o_addr, 32'h300);
                check_val("s4_count", 32'(o_count), 32'd0);
            end
            if (i == 5 - BYP) check_val("s4_pc", o_pc, 32'h300);
        end

        // PC wrap-around.
        do_reset(1);
        for (int i = 0; i < 3; i++) begin
            if (i == 0) begin
                br        = 1'b1;
                br_target = 32'hFFFF_FFFC;
            end
            if (i == 1) br = 1'b0;
            tick();
            if (i == 1) check_val("s5_addr_top", o_addr, 32'hFFFF_FFFC);
            if (i == 2) begin
                check_val("s5_req", 32'(o_req), 32'd1);
                check_val("s5_addr_wrap", o_addr, 32'h0);
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
